// File: rtl/i2s_rx.sv
// I2S receiver: synchronises sck/ws/sd into clk_in, deframes standard I2S and presents L/R pairs on valid/ready.
// Optional define I2S_RX_OVERRUN_CNT_EN adds a saturating 16-bit overrun_count output.
`timescale 1ns/1ps
module i2s_rx #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] output_l_tdata,
  output logic [WIDTH-1:0] output_r_tdata,
  output logic             output_tvalid,
  input  logic             output_tready,
  output logic             overrun
`ifdef I2S_RX_OVERRUN_CNT_EN
  ,
  output logic [15:0]      overrun_count
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic                   sck_s, ws_s, sd_s, sck_q, rise;
  logic                   ws_d1, ws_d2, word_start;
  logic [WIDTH-1:0]       word_buf, left_hold, msb_bit;
  logic [CW-1:0]          cnt;
  logic                   have_left;
  logic                   commit_left, commit_pair;
  state_t                 state, state_next;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_q    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd};
      sck_q    <= sck_s;
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign ws_s  = ws_sync[SYNC_STAGES-1];
  assign sd_s  = sd_sync[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_q;

  // ws_d1 is the channel of the bit on the current rise (1-bit I2S delay)
  assign word_start = rise && (ws_d1 != ws_d2);
  assign msb_bit    = {sd_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    commit_left = 1'b0;
    commit_pair = 1'b0;
    if (word_start) begin
      case (state)
        ST_SYNC:  if (!ws_d1) state_next = ST_LEFT;
        ST_LEFT: begin
          state_next  = ST_RIGHT;
          commit_left = 1'b1;
        end
        ST_RIGHT: begin
          state_next  = ST_LEFT;
          commit_pair = have_left;
        end
        default:  state_next = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ws_d1     <= 1'b0;
      ws_d2     <= 1'b0;
      word_buf  <= '0;
      cnt       <= '0;
      left_hold <= '0;
      have_left <= 1'b0;
    end else if (rise) begin
      ws_d1 <= ws_s;
      ws_d2 <= ws_d1;
      if (word_start) begin
        word_buf <= msb_bit;
        cnt      <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        word_buf <= word_buf | (msb_bit >> cnt);
        cnt      <= cnt + 1'b1;
      end
      if (commit_left) begin
        left_hold <= word_buf;
        have_left <= 1'b1;
      end else if (word_start && state == ST_RIGHT) begin
        have_left <= 1'b0;
      end
    end
  end

  // A completion always wins over the accept in the same cycle, so tvalid stays high
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      output_l_tdata <= '0;
      output_r_tdata <= '0;
      output_tvalid  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_pair) begin
        if (!output_tvalid || output_tready) begin
          output_l_tdata <= left_hold;
          output_r_tdata <= word_buf;
          output_tvalid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (output_tvalid && output_tready) begin
        output_tvalid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVERRUN_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                              overrun_count <= '0;
    else if (overrun && overrun_count != '1) overrun_count <= overrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: sck = clk_in/8, frames driven MSB first with standard I2S ws timing.
`timescale 1ns/1ps
module tb_i2s_rx;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sck, ws, sd;
  logic [23:0] output_l_tdata, output_r_tdata;
  logic        output_tvalid, output_tready, overrun;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int tv_fell = 0;
  logic prev_tv = 1'b0;
  logic [23:0] acc_l[$];
  logic [23:0] acc_r[$];

  i2s_rx #(.WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .sck(sck),
    .ws(ws),
    .sd(sd),
    .output_l_tdata(output_l_tdata),
    .output_r_tdata(output_r_tdata),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready),
    .overrun(overrun)
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Outputs and tready are stable at the falling edge; a handshake seen here completes at the next rising edge
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (output_tvalid && output_tready) begin
        acc_l.push_back(output_l_tdata);
        acc_r.push_back(output_r_tdata);
      end
      if (overrun) ovr_cnt++;
      if (prev_tv && !output_tvalid) tv_fell++;
      prev_tv = output_tvalid;
    end
  end

  task automatic send_bit(input logic w, input logic d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    repeat (4) @(negedge clk_in);
    sck = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic send_word(input logic [31:0] v, input int n, input logic w);
    logic [31:0] t;
    t = v << (32 - n);
    for (int i = 0; i < n; i++) begin
      send_bit((i == n - 1) ? ~w : w, t[31]);
      t = t << 1;
    end
  endtask

  task automatic send_frame(input logic [31:0] lv, input logic [31:0] rv, input int n);
    send_word(lv, n, 1'b0);
    send_word(rv, n, 1'b1);
  endtask

  task automatic send_preamble();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic send_tail();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_in);
    #2 output_tready = v;
    @(negedge clk_in);
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk_in);
    rst_in = 1'b1;
    sck = 1'b0;
    ws  = 1'b0;
    sd  = 1'b0;
    output_tready = rdy;
    repeat (3) @(negedge clk_in);
    acc_l.delete();
    acc_r.delete();
    ovr_cnt = 0;
    tv_fell = 0;
    prev_tv = 1'b0;
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    sck = 1'b0;
    ws  = 1'b0;
    sd  = 1'b0;
    output_tready = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (output_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", output_tvalid); end
    checks++; if (output_l_tdata !== 24'h0) begin errors++; $display("FAIL reset_l got %h want 000000", output_l_tdata); end
    checks++; if (output_r_tdata !== 24'h0) begin errors++; $display("FAIL reset_r got %h want 000000", output_r_tdata); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
`ifdef I2S_RX_OVERRUN_CNT_EN
    checks++; if (overrun_count !== 16'd0) begin errors++; $display("FAIL reset_ovr_count got %0d want 0", overrun_count); end
`endif
    rst_in = 1'b0;
  endtask

  task automatic test_basic();
    do_reset(1'b1);
    send_preamble();
    send_frame(32'hA5A5A5, 32'h5A5A5A, 24);
    send_tail();
    repeat (10) @(negedge clk_in);
    checks++; if (acc_l.size() !== 1) begin errors++; $display("FAIL basic_pairs got %0d want 1", acc_l.size()); end
    if (acc_l.size() > 0) begin
      checks++; if (acc_l[0] !== 24'hA5A5A5) begin errors++; $display("FAIL basic_l got %h want a5a5a5", acc_l[0]); end
      checks++; if (acc_r[0] !== 24'h5A5A5A) begin errors++; $display("FAIL basic_r got %h want 5a5a5a", acc_r[0]); end
    end
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL basic_overrun got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_mid_start();
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_frame(32'h13579B, 32'h2468AC, 24);
    send_tail();
    repeat (10) @(negedge clk_in);
    checks++; if (acc_l.size() !== 1) begin errors++; $display("FAIL mid_pairs got %0d want 1", acc_l.size()); end
    if (acc_l.size() > 0) begin
      checks++; if (acc_l[0] !== 24'h13579B) begin errors++; $display("FAIL mid_l got %h want 13579b", acc_l[0]); end
      checks++; if (acc_r[0] !== 24'h2468AC) begin errors++; $display("FAIL mid_r got %h want 2468ac", acc_r[0]); end
    end
  endtask

  task automatic test_word_length();
    do_reset(1'b1);
    send_preamble();
    send_frame(32'h123456FF, 32'h89ABCDEF, 32);
    send_frame(32'hBEEF, 32'hCAFE, 16);
    send_tail();
    repeat (10) @(negedge clk_in);
    checks++; if (acc_l.size() !== 2) begin errors++; $display("FAIL len_pairs got %0d want 2", acc_l.size()); end
    if (acc_l.size() > 1) begin
      checks++; if (acc_l[0] !== 24'h123456) begin errors++; $display("FAIL trunc_l got %h want 123456", acc_l[0]); end
      checks++; if (acc_r[0] !== 24'h89ABCD) begin errors++; $display("FAIL trunc_r got %h want 89abcd", acc_r[0]); end
      checks++; if (acc_l[1] !== 24'hBEEF00) begin errors++; $display("FAIL pad_l got %h want beef00", acc_l[1]); end
      checks++; if (acc_r[1] !== 24'hCAFE00) begin errors++; $display("FAIL pad_r got %h want cafe00", acc_r[1]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    send_preamble();
    send_frame(32'h0F1E2D, 32'h3C4B5A, 24);
    send_frame(32'h123123, 32'h456456, 24);
    send_frame(32'h789789, 32'hABCABC, 24);
    send_tail();
    repeat (10) @(negedge clk_in);
    checks++; if (output_tvalid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", output_tvalid); end
    checks++; if (output_l_tdata !== 24'h0F1E2D) begin errors++; $display("FAIL bp_hold_l got %h want 0f1e2d", output_l_tdata); end
    checks++; if (output_r_tdata !== 24'h3C4B5A) begin errors++; $display("FAIL bp_hold_r got %h want 3c4b5a", output_r_tdata); end
    checks++; if (ovr_cnt !== 2) begin errors++; $display("FAIL bp_overruns got %0d want 2", ovr_cnt); end
`ifdef I2S_RX_OVERRUN_CNT_EN
    checks++; if (overrun_count !== 16'd2) begin errors++; $display("FAIL bp_ovr_count got %0d want 2", overrun_count); end
`endif
    set_ready(1'b1);
    repeat (5) @(negedge clk_in);
    checks++; if (acc_l.size() !== 1) begin errors++; $display("FAIL bp_accepts got %0d want 1", acc_l.size()); end
    if (acc_l.size() > 0) begin
      checks++; if (acc_l[0] !== 24'h0F1E2D) begin errors++; $display("FAIL bp_accept_l got %h want 0f1e2d", acc_l[0]); end
    end
    checks++; if (output_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got %b want 0", output_tvalid); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    send_preamble();
    send_frame(32'h111222, 32'h333444, 24);
    send_frame(32'h555666, 32'h777888, 24);
    // tail bit: its rise is seen in the third clk_in cycle after sck rises, so raise tready in that cycle
    sck = 1'b0;
    ws  = 1'b0;
    sd  = 1'b0;
    repeat (4) @(negedge clk_in);
    sck = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #2 output_tready = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    checks++; if (output_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", output_tvalid); end
    checks++; if (output_l_tdata !== 24'h555666) begin errors++; $display("FAIL b2b_l got %h want 555666", output_l_tdata); end
    checks++; if (output_r_tdata !== 24'h777888) begin errors++; $display("FAIL b2b_r got %h want 777888", output_r_tdata); end
    checks++; if (tv_fell !== 0) begin errors++; $display("FAIL b2b_no_drop got %0d want 0", tv_fell); end
    repeat (3) @(negedge clk_in);
    send_bit(1'b0, 1'b0);
    repeat (5) @(negedge clk_in);
    checks++; if (acc_l.size() !== 2) begin errors++; $display("FAIL b2b_accepts got %0d want 2", acc_l.size()); end
    if (acc_l.size() > 1) begin
      checks++; if (acc_l[0] !== 24'h111222) begin errors++; $display("FAIL b2b_first_l got %h want 111222", acc_l[0]); end
      checks++; if (acc_r[1] !== 24'h777888) begin errors++; $display("FAIL b2b_second_r got %h want 777888", acc_r[1]); end
    end
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL b2b_overrun got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] t;
    do_reset(1'b0);
    send_preamble();
    send_frame(32'hDEAD01, 32'hBEEF02, 24);
    send_word(32'h0A0B0C, 24, 1'b0);
    t = 32'hF0F0F000;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, t[31]);
      t = t << 1;
    end
    checks++; if (output_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", output_tvalid); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (output_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", output_tvalid); end
    checks++; if (output_l_tdata !== 24'h0) begin errors++; $display("FAIL rmid_l got %h want 000000", output_l_tdata); end
    checks++; if (output_r_tdata !== 24'h0) begin errors++; $display("FAIL rmid_r got %h want 000000", output_r_tdata); end
    do_reset(1'b1);
    send_preamble();
    send_frame(32'h0C0FFE, 32'hFACADE, 24);
    send_tail();
    repeat (10) @(negedge clk_in);
    checks++; if (acc_l.size() !== 1) begin errors++; $display("FAIL rmid_pairs got %0d want 1", acc_l.size()); end
    if (acc_l.size() > 0) begin
      checks++; if (acc_l[0] !== 24'h0C0FFE) begin errors++; $display("FAIL rmid_next_l got %h want 0c0ffe", acc_l[0]); end
      checks++; if (acc_r[0] !== 24'hFACADE) begin errors++; $display("FAIL rmid_next_r got %h want facade", acc_r[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_start();
    test_word_length();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
